// File: rtl/elevator_call_register.sv
// elevator_call_register: synchronise, debounce and edge-detect seven call buttons,
// holding each request until the controller's matching clear releases it.
module elevator_call_register #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw_floor_1_up,
    input  logic raw_floor_2_up,
    input  logic raw_floor_2_down,
    input  logic raw_floor_3_down,
    input  logic raw_elevator_floor_1,
    input  logic raw_elevator_floor_2,
    input  logic raw_elevator_floor_3,
    input  logic floor_1_up_button_clear,
    input  logic floor_2_up_button_clear,
    input  logic floor_2_down_button_clear,
    input  logic floor_3_down_button_clear,
    input  logic elevator_floor_1_button_clear,
    input  logic elevator_floor_2_button_clear,
    input  logic elevator_floor_3_button_clear,
    output logic floor_1_up_button,
    output logic floor_2_up_button,
    output logic floor_2_down_button,
    output logic floor_3_down_button,
    output logic elevator_floor_1_button,
    output logic elevator_floor_2_button,
    output logic elevator_floor_3_button,
    output logic request_pending
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [6:0] raw, clr, req;
    assign raw = {raw_elevator_floor_3, raw_elevator_floor_2, raw_elevator_floor_1,
                  raw_floor_3_down, raw_floor_2_down, raw_floor_2_up, raw_floor_1_up};
    assign clr = {elevator_floor_3_button_clear, elevator_floor_2_button_clear,
                  elevator_floor_1_button_clear, floor_3_down_button_clear,
                  floor_2_down_button_clear, floor_2_up_button_clear, floor_1_up_button_clear};
    assign {elevator_floor_3_button, elevator_floor_2_button, elevator_floor_1_button,
            floor_3_down_button, floor_2_down_button, floor_2_up_button,
            floor_1_up_button} = req;
    assign request_pending = |req;
    genvar g;
    generate
        for (g = 0; g < 7; g++) begin : ch
            logic sync1, sync2, db, q, rise;
            logic [CNT_W-1:0] cnt;
            // rise is asserted on the same edge that flips db from 0 to 1
            assign rise = ~db && sync2 && cnt == LAST;
            assign req[g] = q;
            always_ff @(posedge clk or negedge rstn)
                if (!rstn) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                    db    <= 1'b0;
                    cnt   <= '0;
                    q     <= 1'b0;
                end else begin
                    sync1 <= raw[g];
                    sync2 <= sync1;
                    if (sync2 == db) cnt <= '0;
                    else if (cnt == LAST) begin
                        db  <= sync2;
                        cnt <= '0;
                    end else cnt <= cnt + 1'b1;
                    q <= clr[g] ? 1'b0 : (rise ? 1'b1 : q);
                end
        end
    endgenerate
endmodule

// File: tb/tb_elevator_call_register.sv
// tb_elevator_call_register: directed checks of debounce latency, clear dominance,
// held-button behaviour, independence and asynchronous reset.
module tb_elevator_call_register;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [6:0] raw = '0, clr = '0, req;
    logic pending;
    int checks = 0, failures = 0;

    elevator_call_register dut (
        .clk(clk), .rstn(rstn),
        .raw_floor_1_up(raw[0]), .raw_floor_2_up(raw[1]),
        .raw_floor_2_down(raw[2]), .raw_floor_3_down(raw[3]),
        .raw_elevator_floor_1(raw[4]), .raw_elevator_floor_2(raw[5]),
        .raw_elevator_floor_3(raw[6]),
        .floor_1_up_button_clear(clr[0]), .floor_2_up_button_clear(clr[1]),
        .floor_2_down_button_clear(clr[2]), .floor_3_down_button_clear(clr[3]),
        .elevator_floor_1_button_clear(clr[4]), .elevator_floor_2_button_clear(clr[5]),
        .elevator_floor_3_button_clear(clr[6]),
        .floor_1_up_button(req[0]), .floor_2_up_button(req[1]),
        .floor_2_down_button(req[2]), .floor_3_down_button(req[3]),
        .elevator_floor_1_button(req[4]), .elevator_floor_2_button(req[5]),
        .elevator_floor_3_button(req[6]),
        .request_pending(pending)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [7:0] got, want;
        got  = {pending, req};
        want = {|exp, exp};
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s pending_req=%h expected=%h", tag, got, want);
        end
    endtask

    initial begin
        #12;
        chk("reset_state", 7'h00);
        @(posedge clk);
        #1 rstn = 1'b1;
        step(1);
        chk("idle_after_reset", 7'h00);

        raw[1] = 1'b1;
        step(5);
        chk("press_edge5", 7'h00);
        step(1);
        chk("press_edge6", 7'h02);
        step(4);
        raw[1] = 1'b0;
        step(8);
        chk("release_keeps", 7'h02);
        clr[1] = 1'b1;
        step(1);
        chk("clear_f2up", 7'h00);
        clr[1] = 1'b0;

        raw[6] = 1'b1;
        step(3);
        raw[6] = 1'b0;
        step(10);
        chk("glitch_rejected", 7'h00);
        raw[6] = 1'b1;
        step(2);
        raw[6] = 1'b0;
        step(1);
        raw[6] = 1'b1;
        step(5);
        chk("bounce_edge8", 7'h00);
        step(1);
        chk("bounce_edge9", 7'h40);
        clr[6] = 1'b1;
        raw[6] = 1'b0;
        step(1);
        chk("clear_e3", 7'h00);
        clr[6] = 1'b0;
        step(8);

        raw[0] = 1'b1;
        step(6);
        chk("f1up_latched", 7'h01);
        raw[0] = 1'b0;
        step(8);
        chk("f1up_released", 7'h01);
        raw[0] = 1'b1;
        step(2);
        clr[0] = 1'b1;
        step(1);
        chk("clear_first_edge", 7'h00);
        step(4);
        chk("rise_in_clear_dropped", 7'h00);
        clr[0] = 1'b0;
        step(1);
        chk("after_clear_drop", 7'h00);
        step(5);
        chk("held_no_defer", 7'h00);
        raw[0] = 1'b0;
        step(8);

        raw[3] = 1'b1;
        step(6);
        chk("f3down_latched", 7'h08);
        clr[3] = 1'b1;
        step(1);
        chk("f3down_cleared", 7'h00);
        clr[3] = 1'b0;
        step(5);
        chk("held_no_retrigger", 7'h00);
        raw[3] = 1'b0;
        step(6);
        raw[3] = 1'b1;
        step(5);
        chk("repress_edge5", 7'h00);
        step(1);
        chk("repress_edge6", 7'h08);
        clr[3] = 1'b1;
        raw[3] = 1'b0;
        step(1);
        clr[3] = 1'b0;
        step(8);
        chk("idle_before_all", 7'h00);

        raw = 7'h7f;
        step(5);
        chk("all_edge5", 7'h00);
        step(1);
        chk("all_edge6", 7'h7f);
        clr[5] = 1'b1;
        step(1);
        chk("clear_e2_only", 7'h5f);
        clr[5] = 1'b0;

        #2 rstn = 1'b0;
        #1;
        chk("async_reset_latched", 7'h00);
        raw = '0;
        step(2);
        rstn = 1'b1;
        step(1);
        raw[2] = 1'b1;
        step(4);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_mid_debounce", 7'h00);
        step(1);
        rstn = 1'b1;
        step(5);
        chk("held_reset_edge5", 7'h00);
        step(1);
        chk("held_reset_edge6", 7'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
